// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the register file's single
// registered write port and tracks in-flight destination registers for hazard detection.
module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,

    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,

    input  logic                   pend_set,
    input  logic [ADDR_W-1:0]      pend_addr,
    input  logic [ADDR_W-1:0]      query_addr1,
    input  logic [ADDR_W-1:0]      query_addr2,
    output logic                   hazard1,
    output logic                   hazard2,

    output logic                   write_enable1,
    output logic [ADDR_W-1:0]      write_addr,
    output logic [DATA_W-1:0]      write_data,
    output logic [2**ADDR_W-1:0]   pending
);

    localparam int NREG = 2**ADDR_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // Holding slots
    logic              alu_occ_q,  alu_occ_d;
    logic [ADDR_W-1:0] alu_addr_q, alu_addr_d;
    logic [DATA_W-1:0] alu_data_q, alu_data_d;
    logic              mem_occ_q,  mem_occ_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;

    // Ordering / fairness state
    logic              alu_older_q, alu_older_d;
    src_e              rr_q,        rr_d;

    // Write port and scoreboard
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]   pend_q,  pend_d;

    logic both_occ;
    logic grant_alu;
    logic grant_mem;
    logic cap_alu;
    logic cap_mem;

    // NOTE: every signal assigned in an always_comb gets a default at the top of the
    // block; a path that skips the assignment would otherwise infer a latch.
    always_comb begin
        both_occ  = alu_occ_q && mem_occ_q;
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (both_occ) begin
            // Same destination: the older result must land first or the register ends stale.
            if (alu_addr_q == mem_addr_q) begin
                grant_alu = alu_older_q;
            end else begin
                grant_alu = (rr_q == SRC_ALU);
            end
            grant_mem = !grant_alu;
        end else begin
            grant_alu = alu_occ_q;
            grant_mem = mem_occ_q;
        end
    end

    // A slot being drained this cycle can be refilled on the same edge.
    assign alu_ready = !alu_occ_q || grant_alu;
    assign mem_ready = !mem_occ_q || grant_mem;
    assign cap_alu   = alu_valid && alu_ready;
    assign cap_mem   = mem_valid && mem_ready;

    always_comb begin
        alu_occ_d  = alu_occ_q;
        alu_addr_d = alu_addr_q;
        alu_data_d = alu_data_q;
        if (cap_alu) begin
            alu_occ_d  = 1'b1;
            alu_addr_d = alu_addr;
            alu_data_d = alu_data;
        end else if (grant_alu) begin
            alu_occ_d  = 1'b0;
        end

        mem_occ_d  = mem_occ_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (cap_mem) begin
            mem_occ_d  = 1'b1;
            mem_addr_d = mem_addr;
            mem_data_d = mem_data;
        end else if (grant_mem) begin
            mem_occ_d  = 1'b0;
        end
    end

    always_comb begin
        alu_older_d = alu_older_q;
        if (cap_alu && cap_mem) begin
            alu_older_d = 1'b1;
        end else if (cap_alu && (!mem_occ_q || grant_mem)) begin
            alu_older_d = 1'b1;
        end else if (cap_mem && (!alu_occ_q || grant_alu)) begin
            alu_older_d = 1'b0;
        end

        // After a contended grant the pointer favours the loser next time.
        rr_d = rr_q;
        if (both_occ) begin
            rr_d = grant_alu ? SRC_MEM : SRC_ALU;
        end
    end

    always_comb begin
        we_d    = grant_alu || grant_mem;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant_alu) begin
            waddr_d = alu_addr_q;
            wdata_d = alu_data_q;
        end else if (grant_mem) begin
            waddr_d = mem_addr_q;
            wdata_d = mem_data_q;
        end

        // Set is applied after clear so a same-register collision stays pending.
        pend_d = pend_q;
        if (we_q) begin
            pend_d[waddr_q] = 1'b0;
        end
        if (pend_set) begin
            pend_d[pend_addr] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    // NOTE: the scoreboard and slot payloads are flop arrays, not a RAM, and are reset
    // explicitly so decode never sees a spurious hazard or a stale write after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_occ_q   <= 1'b0;
            alu_addr_q  <= '0;
            alu_data_q  <= '0;
            mem_occ_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            alu_older_q <= 1'b0;
            rr_q        <= SRC_ALU;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pend_q      <= '0;
        end else begin
            alu_occ_q   <= alu_occ_d;
            alu_addr_q  <= alu_addr_d;
            alu_data_q  <= alu_data_d;
            mem_occ_q   <= mem_occ_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            alu_older_q <= alu_older_d;
            rr_q        <= rr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            pend_q      <= pend_d;
        end
    end

    assign write_enable1 = we_q;
    assign write_addr    = waddr_q;
    assign write_data    = wdata_q;
    assign pending       = pend_q;
    assign hazard1       = pend_q[query_addr1];
    assign hazard2       = pend_q[query_addr2];

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
        !(grant_alu && grant_mem));
    a_grant_needs_occ: assert property (@(posedge clk) disable iff (!rst)
        (!grant_alu || alu_occ_q) && (!grant_mem || mem_occ_q));

endmodule
